// File: rtl/uart_msg_rx.sv
// 8N1 UART receiver that packs MSG_BYTES accepted bytes into one message word.
// Optional inter-byte idle timeout enabled by defining RX_TIMEOUT_EN.
module uart_msg_rx #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned MSG_BYTES    = 11,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   uart_rx,
  output logic [8*MSG_BYTES-1:0] o_msg,
  output logic                   o_valid,
  output logic                   o_frame_err,
  output logic                   o_timeout,
  output logic                   o_led_msg,
  output logic                   o_led_err
);

  localparam int unsigned MSG_W = 8 * MSG_BYTES;
  localparam int unsigned CLK_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned CNT_W = $clog2(MSG_BYTES + 1);
  localparam logic [CLK_W-1:0] HALF_M1   = CLK_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CLK_W-1:0] BIT_M1    = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(MSG_BYTES - 1);

  if (CLKS_PER_BIT < 4 || MSG_BYTES < 1 || TIMEOUT_BITS < 1) begin : g_param_check
    $error("uart_msg_rx: parameter out of legal range");
  end

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t             state, state_nxt;
  logic               rx_meta, rxs;
  logic [CLK_W-1:0]   clk_cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         data_byte;
  logic [MSG_W-1:0]   asm_q;
  logic [CNT_W-1:0]   byte_cnt;
  logic               tick_c, byte_ok_c, frame_err_c, timeout_c;

  // Two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    tick_c      = 1'b0;
    byte_ok_c   = 1'b0;
    frame_err_c = 1'b0;
    case (state)
      IDLE:  if (!rxs) state_nxt = START;
      START: if (clk_cnt == HALF_M1) begin
               tick_c    = 1'b1;
               state_nxt = rxs ? IDLE : DATA;
             end
      DATA:  if (clk_cnt == BIT_M1) begin
               tick_c = 1'b1;
               if (bit_idx == 3'd7) state_nxt = STOP;
             end
      STOP:  if (clk_cnt == BIT_M1) begin
               tick_c = 1'b1;
               if (rxs) begin
                 state_nxt = IDLE;
                 byte_ok_c = 1'b1;
               end else begin
                 state_nxt   = BREAK;
                 frame_err_c = 1'b1;
               end
             end
      BREAK: if (rxs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bit timing and LSB-first deserialisation
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      clk_cnt   <= '0;
      bit_idx   <= '0;
      data_byte <= '0;
    end else begin
      if (tick_c || state == IDLE || state == BREAK) clk_cnt <= '0;
      else                                           clk_cnt <= clk_cnt + CLK_W'(1);
      if (state == IDLE)
        bit_idx <= '0;
      else if (state == DATA && tick_c) begin
        bit_idx   <= bit_idx + 3'd1;
        data_byte <= {rxs, data_byte[7:1]};
      end
    end
  end

  // Message assembly; the newest byte always lands in the low byte
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      asm_q       <= '0;
      byte_cnt    <= '0;
      o_msg       <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_led_msg   <= 1'b0;
      o_led_err   <= 1'b0;
    end else begin
      o_valid     <= 1'b0;
      o_frame_err <= frame_err_c;
      if (frame_err_c) o_led_err <= 1'b1;
      if (frame_err_c || timeout_c) begin
        byte_cnt <= '0;
      end else if (byte_ok_c) begin
        asm_q <= MSG_W'({asm_q, data_byte});
        if (byte_cnt == LAST_BYTE) begin
          byte_cnt  <= '0;
          o_msg     <= MSG_W'({asm_q, data_byte});
          o_valid   <= 1'b1;
          o_led_msg <= ~o_led_msg;
        end else begin
          byte_cnt <= byte_cnt + CNT_W'(1);
        end
      end
    end
  end

`ifdef RX_TIMEOUT_EN
  localparam int unsigned TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned IDLE_W    = $clog2(TO_CYCLES + 1);

  logic [IDLE_W-1:0] idle_cnt;

  assign timeout_c = (state == IDLE) && (byte_cnt != '0) &&
                     (idle_cnt == IDLE_W'(TO_CYCLES - 1));

  // Idle time only accrues while a partial message is pending
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      idle_cnt  <= '0;
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= timeout_c;
      if (state != IDLE || byte_cnt == '0 || timeout_c) idle_cnt <= '0;
      else                                              idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end
`else
  assign timeout_c = 1'b0;
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_msg_rx.sv
// Bench for uart_msg_rx: directed scenarios plus random bytes against a byte-queue model.
// Honours RX_TIMEOUT_EN the same way the design does.
module tb_uart_msg_rx;

  localparam int unsigned CPB   = 16;
  localparam int unsigned NB    = 3;
  localparam int unsigned TOB   = 20;
  localparam int unsigned MSG_W = 8 * NB;
`ifdef RX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             rx;
  logic [MSG_W-1:0] msg;
  logic             valid, frame_err, timeout, led_msg, led_err;

  always #5 clk = ~clk;

  uart_msg_rx #(.CLKS_PER_BIT(CPB), .MSG_BYTES(NB), .TIMEOUT_BITS(TOB)) dut (
    .i_clk(clk), .i_rst(rst), .uart_rx(rx),
    .o_msg(msg), .o_valid(valid), .o_frame_err(frame_err),
    .o_timeout(timeout), .o_led_msg(led_msg), .o_led_err(led_err)
  );

  int checks = 0;
  int failures = 0;

  // Observed pulses
  int               valid_cnt = 0, ferr_cnt = 0, to_cnt = 0;
  logic [MSG_W-1:0] obs_q[$];

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      valid_cnt++;
      obs_q.push_back(msg);
    end
    if (frame_err === 1'b1) ferr_cnt++;
    if (timeout === 1'b1) to_cnt++;
  end

  // Reference model: pending bytes, expected messages and pulse totals
  byte unsigned     part_q[$];
  logic [MSG_W-1:0] exp_q[$];
  logic [MSG_W-1:0] exp_last = '0;
  int               exp_valid = 0, exp_ferr = 0, exp_to = 0, valids_since_rst = 0;
  bit               exp_led_err = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_byte(input byte unsigned b, input bit ok);
    logic [MSG_W-1:0] m;
    if (!ok) begin
      part_q.delete();
      exp_ferr++;
      exp_led_err = 1'b1;
    end else begin
      part_q.push_back(b);
      if (part_q.size() == NB) begin
        m = '0;
        foreach (part_q[i]) m = (m << 8) | MSG_W'(part_q[i]);
        exp_q.push_back(m);
        exp_last = m;
        exp_valid++;
        valids_since_rst++;
        part_q.delete();
      end
    end
  endtask

  task automatic line_bits(input bit v, input int n);
    rx = v;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic send_byte(input byte unsigned b, input bit ok);
    line_bits(1'b0, 1);
    for (int i = 0; i < 8; i++) line_bits(b[i], 1);
    line_bits(ok, 1);
    if (!ok) line_bits(1'b1, 1);
    model_byte(b, ok);
  endtask

  task automatic idle(input int n);
    line_bits(1'b1, n);
    if (TO_EN && n >= TOB && part_q.size() > 0) begin
      part_q.delete();
      exp_to++;
    end
  endtask

  task automatic verify(input string tag);
    logic [MSG_W-1:0] o, e;
    check({tag, "_valid_cnt"}, 64'(valid_cnt), 64'(exp_valid));
    check({tag, "_ferr_cnt"}, 64'(ferr_cnt), 64'(exp_ferr));
    check({tag, "_to_cnt"}, 64'(to_cnt), 64'(exp_to));
    check({tag, "_msg"}, 64'(msg), 64'(exp_last));
    check({tag, "_led_msg"}, 64'(led_msg), 64'(valids_since_rst % 2));
    check({tag, "_led_err"}, 64'(led_err), 64'(exp_led_err));
    check({tag, "_nmsgs"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_msg_seq"}, 64'(o), 64'(e));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_msg"}, 64'(msg), 64'd0);
    check({tag, "_valid"}, 64'(valid), 64'd0);
    check({tag, "_frame_err"}, 64'(frame_err), 64'd0);
    check({tag, "_timeout"}, 64'(timeout), 64'd0);
    check({tag, "_led_msg"}, 64'(led_msg), 64'd0);
    check({tag, "_led_err"}, 64'(led_err), 64'd0);
  endtask

  initial begin
    byte unsigned b;
    bit ok;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    idle(2);

    // Back-to-back message
    send_byte(8'h41, 1'b1);
    send_byte(8'h42, 1'b1);
    send_byte(8'h43, 1'b1);
    idle(2);
    check("basic_expected_msg", 64'(exp_last), 64'h414243);
    verify("basic");

    // Short low glitch must be rejected silently
    rx = 1'b0;
    repeat (4) @(negedge clk);
    idle(3);
    verify("glitch");

    // Bad stop bit drops the partial message
    send_byte(8'h41, 1'b1);
    send_byte(8'h42, 1'b0);
    send_byte(8'h43, 1'b1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h45, 1'b1);
    idle(2);
    verify("frame_err");

    // Long break: a single error, then normal traffic
    line_bits(1'b0, 40);
    model_byte(8'h00, 1'b0);
    idle(2);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    idle(2);
    verify("break");

    // Long inter-byte gap
    send_byte(8'h11, 1'b1);
    idle(25);
    send_byte(8'h21, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h23, 1'b1);
    idle(2);
    verify("gap");

    // Reset in the middle of the 5th data bit of the second byte
    send_byte(8'hAA, 1'b1);
    b = 8'hBB;
    line_bits(1'b0, 1);
    for (int i = 0; i < 4; i++) line_bits(b[i], 1);
    rx = b[4];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("midreset");
    rst = 1'b0;
    part_q.delete();
    exp_last = '0;
    valids_since_rst = 0;
    exp_led_err = 1'b0;
    obs_q.delete();
    exp_q.delete();
    idle(2);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1);
    idle(2);
    verify("after_reset");

    // Random bytes, occasional bad stop bits, short gaps
    for (int n = 0; n < 30; n++) begin
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 5) != 0);
      send_byte(b, ok);
      idle(int'($urandom_range(0, 3)));
    end
    idle(2);
    verify("random");
    check("final_timeout_low", 64'(timeout), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_msg_rx.md
UART_MSG_RX -- requirements
Module: uart_msg_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 104, i_clk cycles per UART bit; legal range >= 4.
REQ-002 Parameter MSG_BYTES, default 11, bytes per assembled message; legal range >= 1.
REQ-003 Parameter TIMEOUT_BITS, default 20, inter-byte idle limit in bit times; used only when RX_TIMEOUT_EN is defined.
REQ-004 i_clk  input  1  sole clock, all logic on rising edge.
REQ-005 i_rst  input  1  synchronous, active-high reset.
REQ-006 uart_rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 o_msg  output  8*MSG_BYTES  last complete message; first received byte in bits [8*MSG_BYTES-1 -: 8].
REQ-008 o_valid  output  1  one-cycle pulse when o_msg updates.
REQ-009 o_frame_err  output  1  one-cycle pulse on stop-bit error.
REQ-010 o_timeout  output  1  one-cycle pulse when a partial message is discarded by timeout.
REQ-011 o_led_msg  output  1  toggles on every o_valid.
REQ-012 o_led_err  output  1  sticky, set on any o_frame_err, cleared only by i_rst.

Function
REQ-013 uart_rx SHALL pass through a 2-flop synchronizer before any use; the synchronizer output is "rxs".
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP, BREAK.
REQ-015 IDLE: rxs==0 -> START, bit counter cleared.
REQ-016 START: at count CLKS_PER_BIT/2-1, rxs==0 -> DATA; rxs==1 -> IDLE (glitch rejected, nothing reported).
REQ-017 DATA: samples rxs every CLKS_PER_BIT cycles from mid-start, 8 samples, LSB first; after the 8th -> STOP.
REQ-018 STOP: samples CLKS_PER_BIT cycles after the 8th data sample; rxs==1 -> byte accepted, -> IDLE; rxs==0 -> frame error, -> BREAK.
REQ-019 BREAK: stays until rxs==1, then -> IDLE.
REQ-020 Accepted byte SHALL shift into the assembly register from the LSB end (existing content shifts left 8); byte count increments.
REQ-021 When the accepted byte makes count == MSG_BYTES: o_msg <= assembly value, o_valid pulses in the cycle after the stop sample, count <= 0.
REQ-022 o_msg SHALL hold its value between o_valid pulses; partial messages never appear on o_msg.
REQ-023 Frame error SHALL discard the bad byte and any partial message (count <= 0) and pulse o_frame_err in the cycle after the stop sample.
REQ-024 MSG_BYTES==1: every accepted byte produces o_valid.
REQ-025 Counters SHALL be sized by $clog2 of their maximum value; no wrap occurs within legal parameter ranges.

Reset
REQ-026 i_rst SHALL force state IDLE, synchronizer flops to 1, all counters to 0, assembly register and o_msg to 0, o_valid/o_frame_err/o_timeout/o_led_msg/o_led_err to 0.
REQ-027 i_rst asserted mid-frame SHALL abandon the frame; reception restarts on the next falling edge of rxs after release.
REQ-028 i_rst has priority over every other event in the same cycle.

Configuration
REQ-029 Macro RX_TIMEOUT_EN defined: with count>0 and state IDLE for TIMEOUT_BITS*CLKS_PER_BIT consecutive cycles, count <= 0 and o_timeout pulses one cycle; idle counter clears on leaving IDLE.
REQ-030 RX_TIMEOUT_EN undefined: no timeout logic, o_timeout tied 0, partial messages held indefinitely.

Verification (bench: CLKS_PER_BIT=16, MSG_BYTES=3, TIMEOUT_BITS=20)
REQ-031 Send 0x41,0x42,0x43 back-to-back -> single o_valid, o_msg=0x414243, o_led_msg 0->1, no error pulses.
REQ-032 Low pulse of 4 cycles on idle line -> no state beyond START, no outputs change.
REQ-033 Send 0x41, then byte 0x42 with stop bit low, then 0x43,0x44,0x45 -> one o_frame_err, o_led_err=1, o_valid with o_msg=0x434445.
REQ-034 Hold line low 40 bit times -> one o_frame_err, FSM in BREAK until line high, then 0x01,0x02,0x03 -> o_msg=0x010203.
REQ-035 RX_TIMEOUT_EN: send 0x11, idle 25 bit times, send 0x21,0x22,0x23 -> one o_timeout, o_msg=0x212223; without macro -> o_msg=0x112122, o_timeout never 1.
REQ-036 Assert i_rst during 5th data bit of second byte -> all outputs 0; following 0xAA,0xBB,0xCC -> o_msg=0xAABBCC.
